// File: rtl/bit_expander_if.sv
// Video stream bundle between the binarizer and the expander: 1-bit pixels
// in, DATA_W-bit grey pixels out, both carrying vs/de.
interface bit_expander_if #(
   parameter int DATA_W = 8
);
   logic              pre_vs;
   logic              pre_de;
   logic              pre_bit;
   logic              post_vs;
   logic              post_de;
   logic [DATA_W-1:0] post_data;

   modport master (
      output pre_vs, pre_de, pre_bit,
      input  post_vs, post_de, post_data
   );

   modport slave (
      input  pre_vs, pre_de, pre_bit,
      output post_vs, post_de, post_data
   );
endinterface

// File: rtl/bit_expander.sv
// Re-expands a binary pixel stream into grey levels and counts white pixels
// per frame. Optional MAJORITY_FILTER_EN adds a causal 3-tap speck filter.
module bit_expander #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EN,
   input  logic              invert,
   input  logic [DATA_W-1:0] fg_level,
   input  logic [DATA_W-1:0] bg_level,
   bit_expander_if.slave     vid,
   output logic [CNT_W-1:0]  white_cnt,
   output logic              cnt_valid
);

   typedef enum logic {WAIT_VS, IN_FRAME} state_t;

   state_t            state_reg;
   logic              vs_d_reg;
   logic [DATA_W-1:0] fg_sh_reg;
   logic [DATA_W-1:0] bg_sh_reg;
   logic              inv_sh_reg;
   logic [CNT_W-1:0]  acc_reg;
   logic [CNT_W-1:0]  acc_next;
   logic [CNT_W-1:0]  white_cnt_reg;
   logic              cnt_valid_reg;
   logic              post_vs_reg;
   logic              post_de_reg;
   logic [DATA_W-1:0] post_data_reg;
   logic [DATA_W-1:0] byp_data;

   logic vs_rise;
   logic raw_bit;
   logic eff_bit;
   logic pix_white;

   assign vs_rise = vid.pre_vs & ~vs_d_reg;
   assign raw_bit = vid.pre_bit ^ inv_sh_reg;

`ifdef MAJORITY_FILTER_EN
   logic hist1_reg;
   logic hist2_reg;
   logic de_d_reg;

   // First pixel of a line sees itself replicated into both history taps.
   always_comb begin
      eff_bit = raw_bit;
      if (de_d_reg) begin
         eff_bit = (hist2_reg & hist1_reg) | (hist2_reg & raw_bit) | (hist1_reg & raw_bit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist1_reg <= 1'b0;
         hist2_reg <= 1'b0;
         de_d_reg  <= 1'b0;
      end else begin
         de_d_reg  <= vid.pre_de;
         hist1_reg <= raw_bit;
         if (vid.pre_de && de_d_reg) begin
            hist2_reg <= hist1_reg;
         end else begin
            hist2_reg <= raw_bit;
         end
      end
   end
`else
   assign eff_bit = raw_bit;
`endif

   assign pix_white = vid.pre_de & eff_bit;

   // Accumulator sticks at all-ones rather than wrapping.
   always_comb begin
      acc_next = acc_reg;
      if (pix_white && (acc_reg != {CNT_W{1'b1}})) begin
         acc_next = acc_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= WAIT_VS;
         vs_d_reg      <= 1'b0;
         fg_sh_reg     <= '0;
         bg_sh_reg     <= '0;
         inv_sh_reg    <= 1'b0;
         acc_reg       <= '0;
         white_cnt_reg <= '0;
         cnt_valid_reg <= 1'b0;
         post_vs_reg   <= 1'b0;
         post_de_reg   <= 1'b0;
         post_data_reg <= '0;
      end else begin
         vs_d_reg      <= vid.pre_vs;
         cnt_valid_reg <= 1'b0;
         post_vs_reg   <= vid.pre_vs;
         post_de_reg   <= vid.pre_de;
         post_data_reg <= vid.pre_de ? (eff_bit ? fg_sh_reg : bg_sh_reg) : '0;

         // Levels are frozen per frame so a mid-frame register write never tears the image.
         if (vs_rise) begin
            fg_sh_reg  <= fg_level;
            bg_sh_reg  <= bg_level;
            inv_sh_reg <= invert;
         end

         case (state_reg)
            WAIT_VS: begin
               if (vs_rise) begin
                  state_reg <= IN_FRAME;
                  acc_reg   <= '0;
               end
            end
            IN_FRAME: begin
               if (vs_rise) begin
                  white_cnt_reg <= acc_next;
                  cnt_valid_reg <= 1'b1;
                  acc_reg       <= '0;
               end else begin
                  acc_reg <= acc_next;
               end
            end
            default: state_reg <= WAIT_VS;
         endcase
      end
   end

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_byp
      assign byp_data[gi] = vid.pre_bit;
   end

   assign vid.post_vs   = EN ? post_vs_reg   : vid.pre_vs;
   assign vid.post_de   = EN ? post_de_reg   : vid.pre_de;
   assign vid.post_data = EN ? post_data_reg : byp_data;
   assign white_cnt     = white_cnt_reg;
   assign cnt_valid     = cnt_valid_reg;

endmodule
